// File: rtl/whack_pkg.sv
// Shared constants and types for the whack-a-mole button path.
package whack_pkg;
   localparam int NUM_BUTTONS     = 5;
   localparam int SEL_W           = 3;
   localparam int DEBOUNCE_CYCLES = 2;

   typedef logic [NUM_BUTTONS-1:0] btn_vec_t;
   typedef logic [SEL_W-1:0]       sel_t;
endpackage

// File: rtl/button_conditioner.sv
// One button: 2-flop synchroniser, counter debounce and rising-edge detect.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic button,
   output logic level,
   output logic rise
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             s1, s2, level_d;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1      <= 1'b0;
         s2      <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         cnt     <= '0;
      end else begin
         s1      <= button;
         s2      <= s1;
         level_d <= level;
         // Any sample matching the accepted level restarts the stability count.
         if (s2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level <= s2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign rise = level & ~level_d;
endmodule

// File: rtl/mux_validator.sv
// Registers a one-cycle hit when only the selected mole's button is freshly pressed.
module mux_validator
   import whack_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = whack_pkg::DEBOUNCE_CYCLES
) (
   input  logic     clock,
   input  logic     reset,
   input  btn_vec_t buttons,
   input  sel_t     selector,
   output logic     pulse
);
   btn_vec_t level, rise, sel_oh;
   logic     hit;

   for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
      button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
         .clock  (clock),
         .reset  (reset),
         .button (buttons[g]),
         .level  (level[g]),
         .rise   (rise[g])
      );
   end

   // Out-of-range selectors decode to an empty one-hot, so they can never hit.
   always_comb begin
      sel_oh = '0;
      for (int i = 0; i < NUM_BUTTONS; i++)
         if (selector == SEL_W'(i)) sel_oh[i] = 1'b1;
      hit = (|(rise & sel_oh)) && ((level & ~sel_oh) == '0);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) pulse <= 1'b0;
      else       pulse <= hit;
   end
endmodule

// File: tb/tb_mux_validator.sv
// Directed plus random stimulus against a stability-window reference model.
module tb_mux_validator;
   import whack_pkg::*;

   localparam int D = DEBOUNCE_CYCLES;

   logic     clock = 1'b0;
   logic     reset = 1'b1;
   btn_vec_t buttons = '0;
   sel_t     selector = '0;
   logic     pulse;

   int passed = 0, total = 0;
   int pcount = 0, mcount = 0;

   // Model: captured samples (newest first), accepted levels, expected strobe.
   btn_vec_t hist [0:D];
   btn_vec_t mdeb, mdeb_prev;
   logic     exp_pulse;

   mux_validator dut (
      .clock    (clock),
      .reset    (reset),
      .buttons  (buttons),
      .selector (selector),
      .pulse    (pulse)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
   endtask

   task automatic mreset();
      for (int j = 0; j <= D; j++) hist[j] = '0;
      mdeb = '0;
      mdeb_prev = '0;
      exp_pulse = 1'b0;
   endtask

   // A level is accepted once the last D samples seen by the debouncer all agree on it.
   task automatic model_edge();
      btn_vec_t fresh;
      btn_vec_t others;
      logic     stable;
      fresh = mdeb & ~mdeb_prev;
      if (int'(selector) < NUM_BUTTONS) begin
         others = mdeb;
         others[selector] = 1'b0;
         exp_pulse = fresh[selector] && (others == '0);
      end else begin
         exp_pulse = 1'b0;
      end
      if (exp_pulse) mcount++;
      mdeb_prev = mdeb;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         stable = 1'b1;
         for (int j = 1; j <= D; j++)
            if (hist[j][i] != hist[1][i]) stable = 1'b0;
         if (stable) mdeb[i] = hist[1][i];
      end
      for (int j = D; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = buttons;
   endtask

   task automatic cyc(input btn_vec_t b, input sel_t s, input logic r);
      @(negedge clock);
      buttons  = b;
      selector = s;
      reset    = r;
      if (r) mreset();
      @(posedge clock);
      if (!r) model_edge();
      #1;
      chk("pulse", {31'b0, pulse}, {31'b0, exp_pulse});
      if (pulse === 1'b1) pcount++;
   endtask

   task automatic idle(input sel_t s, input int n);
      for (int k = 0; k < n; k++) cyc('0, s, 1'b0);
   endtask

   initial begin
      int base, mbase, hold;
      btn_vec_t b;
      sel_t     s;
      logic     r;
      mreset();

      // Reset with a button already pressed
      buttons = 5'b00001;
      for (int k = 0; k < 4; k++) begin
         cyc(5'b00001, 3'd0, 1'b1);
         chk("reset_pulse", {31'b0, pulse}, 32'd0);
      end
      for (int e = 1; e <= 8; e++) begin
         cyc(5'b00001, 3'd0, 1'b0);
         chk("reset_latency", {31'b0, pulse}, {31'b0, (e == 5)});
      end
      idle(3'd0, 8);

      // Matching press
      base = pcount;
      for (int k = 0; k < 3; k++) cyc(5'b01000, 3'd3, 1'b0);
      idle(3'd3, 8);
      chk("match_count", pcount - base, 32'd1);

      // Wrong buttons
      base = pcount;
      foreach (hist[j]) ;
      for (int p = 0; p < 4; p++) begin
         b = (p == 3) ? 5'b10000 : btn_vec_t'(5'b00001 << p);
         for (int k = 0; k < 3; k++) cyc(b, 3'd3, 1'b0);
         idle(3'd3, 6);
      end
      chk("wrong_count", pcount - base, 32'd0);

      // Rotating one-hot walk with wandering selector
      base = pcount; mbase = mcount;
      for (int c = 0; c < 90; c++) begin
         b = btn_vec_t'(5'b00001 << ((c / 3) % 5));
         s = sel_t'((3 + c / 9) % 8);
         cyc(b, s, 1'b0);
         if (int'(s) >= NUM_BUTTONS) chk("rot_oor", {31'b0, pulse}, 32'd0);
      end
      idle(3'd0, 8);
      chk("rot_count", pcount - base, mcount - mbase);

      // Glitch rejection then a solid press
      base = pcount;
      cyc(5'b00100, 3'd2, 1'b0);
      idle(3'd2, 8);
      chk("glitch_count", pcount - base, 32'd0);
      for (int k = 0; k < 10; k++) cyc(5'b00100, 3'd2, 1'b0);
      idle(3'd2, 8);
      chk("solid_count", pcount - base, 32'd1);

      // Anti-mash
      base = pcount;
      for (int k = 0; k < 5; k++) cyc(5'b10000, 3'd1, 1'b0);
      for (int k = 0; k < 5; k++) cyc(5'b10010, 3'd1, 1'b0);
      idle(3'd1, 8);
      chk("mash_count", pcount - base, 32'd0);
      for (int k = 0; k < 5; k++) cyc(5'b00010, 3'd1, 1'b0);
      idle(3'd1, 8);
      chk("clean_count", pcount - base, 32'd1);

      // Reset mid-flight with button still held afterwards
      base = pcount;
      cyc(5'b10000, 3'd4, 1'b0);
      for (int k = 0; k < 2; k++) begin
         cyc(5'b10000, 3'd4, 1'b1);
         chk("midreset_pulse", {31'b0, pulse}, 32'd0);
      end
      for (int e = 1; e <= 8; e++) begin
         cyc(5'b10000, 3'd4, 1'b0);
         chk("midreset_latency", {31'b0, pulse}, {31'b0, (e == 5)});
      end
      idle(3'd4, 8);
      chk("midreset_count", pcount - base, 32'd1);

      // Random segment
      base = pcount; mbase = mcount;
      s = '0;
      for (int n = 0; n < 120; n++) begin
         hold = $urandom_range(1, 6);
         case ($urandom_range(0, 9))
            0, 1, 2: b = '0;
            3, 4, 5, 6, 7: b = btn_vec_t'(5'b00001 << $urandom_range(0, NUM_BUTTONS - 1));
            default: b = btn_vec_t'($urandom);
         endcase
         if ($urandom_range(0, 3) == 0) s = sel_t'($urandom_range(0, 7));
         r = ($urandom_range(0, 40) == 0);
         for (int k = 0; k < hold; k++) cyc(b, s, r && (k == 0));
      end
      idle(3'd0, 8);
      chk("rand_count", pcount - base, mcount - mbase);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/mux_validator.md
Name: mux_validator

Overview:
- Validates whack-a-mole button presses against the currently active mole.
- Each of five push-buttons is synchronised, debounced and rising-edge detected.
- Emits a single-cycle `pulse` when the button indexed by `selector` is freshly pressed and no other button is held.
- Sits between the raw board buttons and the score/game-control logic.

Parameters:
- NUM_BUTTONS, 5, number of buttons/moles; `selector` indexes 0..NUM_BUTTONS-1.
- SEL_W, 3, width of `selector`.
- DEBOUNCE_CYCLES, 2, consecutive clock edges a synchronised level must differ from the debounced level before being accepted. Must be >= 1.

Ports:
- clock  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- buttons  input  NUM_BUTTONS  raw asynchronous button levels, 1 = pressed.
- selector  input  SEL_W  index of the active mole. Synchronous to `clock`.
- pulse  output  1  registered one-cycle hit strobe.

Behaviour:
- Reset (async assert, synchronous release): all synchroniser flops, debounce counters, debounced levels, delayed levels and `pulse` go to 0.
- Per-button pipeline, identical for each bit i:
  - 2-flop synchroniser: s1[i] <= buttons[i]; s2[i] <= s1[i].
  - Debounce, comparing s2[i] with deb[i]:
    - If s2[i] == deb[i]: cnt[i] <= 0.
    - If they differ and cnt[i] == DEBOUNCE_CYCLES-1: deb[i] <= s2[i] and cnt[i] <= 0.
    - If they differ otherwise: cnt[i] increments.
    - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - Delay register: deb_d[i] <= deb[i].
  - rise[i] = deb[i] & ~deb_d[i], combinational.
- Hit condition, registered:
  - pulse <= (selector < NUM_BUTTONS) && rise[selector] && (deb & ~onehot(selector)) == 0.
  - `selector` is sampled on the same edge that registers `pulse`, not at press time.
  - Selector values 5..7 (out of range) never produce a pulse and must not index out of range.
- Latency: a level change captured by s1 at edge k gives:
  - s2 change at k+1;
  - deb change at k+1+DEBOUNCE_CYCLES;
  - pulse high from edge k+2+DEBOUNCE_CYCLES for exactly one cycle.
  - With default DEBOUNCE_CYCLES=2 this is 4 edges after the s1 capture.
- Glitch rejection: a synchronised level lasting fewer than DEBOUNCE_CYCLES cycles never reaches deb and gives no pulse.
- Hold: a button held indefinitely yields only one pulse. A new pulse needs a debounced release followed by a press.
- Simultaneous events:
  - If another debounced button is high when the selected one rises, there is no pulse (anti-mash).
  - If the wrong button rises, there is no pulse.
  - Releasing a button never pulses.
- Selector change while the selected button is held: no pulse, because there is no rise.
- Reset mid-operation: pending debounce and pulse are cleared immediately. A button still held after reset must re-debounce, then pulses once if selected.

Decomposition:
- Shared package `whack_pkg`:
  - NUM_BUTTONS and SEL_W constants.
  - Default DEBOUNCE_CYCLES.
  - typedef btn_vec_t (logic [NUM_BUTTONS-1:0]).
  - typedef sel_t (logic [SEL_W-1:0]).
- One natural sub-module, `button_conditioner`: single-bit synchroniser, debounce counter and rise detect. Instantiated NUM_BUTTONS times via generate.
- Top-level `mux_validator` holds the selector mux, the anti-mash check and the `pulse` register.

Test Plan:
- Reset check: assert reset with buttons=5'b00001, selector=0 -> pulse=0 throughout reset. After release, pulse=1 for exactly one cycle, 4 edges after s1 captures the level.
- Matching press: selector=3, buttons=5'b01000 held 3 cycles then 0 -> exactly one pulse of one cycle. Wrong buttons 5'b00001, 5'b00010, 5'b00100, 5'b10000 each held 3 cycles -> no pulse.
- Rotating bench: buttons walk one-hot 00001->00010->...->10000, wrapping, 3 cycles each; selector increments every 9 cycles from 3 through 7 and wraps to 0 -> pulse only when the rising button index equals the selector at pulse time; never for selector 5, 6 or 7.
- Glitch rejection: selector=2, buttons=5'b00100 for 1 cycle -> no pulse. Held 10 cycles -> one pulse.
- Anti-mash: selector=1, hold buttons=5'b10000, then add bit 1 (5'b10010) -> no pulse. Release all, press 5'b00010 alone -> one pulse.
- Async reset mid-flight: selector=4, press 5'b10000, assert reset 1 cycle after the press for 2 cycles -> pulse stays 0 during reset. With the button still held after release, pulse occurs once, 4 edges after the post-reset s1 capture.
